// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU sequencer slice.
package alu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_MUL = 6;
  localparam int OP_CMP = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_RESP
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response bus between a requester (master) and the ALU sequencer (slave).
interface alu_sequencer_if #(
  parameter int word_len = 16,
  parameter int op_len   = 16
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [op_len-1:0]   cmd_op;
  logic [word_len-1:0] cmd_a;
  logic [word_len-1:0] cmd_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [word_len-1:0] rsp_data;
  logic                flag_z;
  logic                flag_n;
  logic                flag_v;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, flag_z, flag_n, flag_v
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, flag_z, flag_n, flag_v
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU; carry reports add carry-out or subtract borrow-out.
module alu
  import alu_pkg::*;
#(
  parameter int word_len = 16,
  parameter int op_len   = 16
) (
  input  logic [word_len-1:0] a,
  input  logic [word_len-1:0] b,
  input  logic [op_len-1:0]   op,
  output logic [word_len-1:0] result,
  output logic                carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      op_len'(OP_ADD): {carry, result} = {1'b0, a} + {1'b0, b};
      op_len'(OP_SUB): {carry, result} = {1'b0, a} - {1'b0, b};
      op_len'(OP_AND): result = a & b;
      op_len'(OP_OR):  result = a | b;
      op_len'(OP_XOR): result = a ^ b;
      op_len'(OP_NOT): result = ~a;
      // Unrecognised opcodes pass operand a through untouched.
      default:         result = a;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences single-cycle ALU ops and a shift-add multiply through one shared ALU.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int word_len = 16,
  parameter int op_len   = 16
) (
  input logic            clk,
  input logic            rst_n,
  alu_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(word_len) + 1;

  state_e              state_q, state_d;
  logic [op_len-1:0]   op_q, op_d;
  logic [word_len-1:0] a_q, a_d;
  logic [word_len-1:0] b_q, b_d;
  logic [word_len-1:0] acc_q, acc_d;
  logic [word_len-1:0] mcand_q, mcand_d;
  logic [word_len-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [word_len-1:0] rsp_data_q, rsp_data_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_n_q, flag_n_d;
  logic                flag_v_q, flag_v_d;

  logic [word_len-1:0] alu_a, alu_b, alu_res;
  logic [op_len-1:0]   alu_op;
  logic                alu_carry;
  logic [word_len-1:0] acc_nx;
  logic                ovf_nx;

  alu #(
    .word_len (word_len),
    .op_len   (op_len)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // During multiply the ALU accumulates; otherwise it sees the latched command, CMP as SUB.
  always_comb begin
    alu_a  = a_q;
    alu_b  = b_q;
    alu_op = op_q;
    if (state_q == ST_MUL) begin
      alu_a  = acc_q;
      alu_b  = mcand_q;
      alu_op = op_len'(OP_ADD);
    end else if (op_q == op_len'(OP_CMP)) begin
      alu_op = op_len'(OP_SUB);
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rsp_data_d = rsp_data_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    flag_v_d   = flag_v_q;
    acc_nx     = acc_q;
    ovf_nx     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d     = bus.cmd_op;
          a_d      = bus.cmd_a;
          b_d      = bus.cmd_b;
          acc_d    = '0;
          mcand_d  = bus.cmd_a;
          mplier_d = bus.cmd_b;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = (bus.cmd_op == op_len'(OP_MUL)) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = (op_q == op_len'(OP_CMP)) ? '0 : alu_res;
        flag_z_d   = (alu_res == '0);
        flag_n_d   = alu_res[word_len-1];
        flag_v_d   = ((op_q == op_len'(OP_ADD)) || (op_q == op_len'(OP_SUB)) ||
                      (op_q == op_len'(OP_CMP))) ? alu_carry : 1'b0;
        state_d    = ST_RESP;
      end
      ST_MUL: begin
        if (mplier_q[0]) begin
          acc_nx = alu_res;
          ovf_nx = ovf_q | alu_carry;
        end
        acc_d    = acc_nx;
        ovf_d    = ovf_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last of word_len steps: publish the product built in this same step.
        if (cnt_q == CNT_W'(word_len - 1)) begin
          rsp_data_d = acc_nx;
          flag_z_d   = (acc_nx == '0);
          flag_n_d   = acc_nx[word_len-1];
          flag_v_d   = ovf_nx;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rsp_data_q <= '0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rsp_data_q <= rsp_data_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
      flag_v_q   <= flag_v_d;
    end
  end

  // cmd_ready is masked by rst_n so nothing looks accepted while held in reset.
  assign bus.cmd_ready = rst_n && (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: each task drives one scenario and checks hand-computed results.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] r_data;
  logic [2:0]  r_flags;
  int          r_lat;

  always #5 clk = ~clk;

  alu_sequencer_if #(.word_len(16), .op_len(16)) bus();

  alu_sequencer #(.word_len(16), .op_len(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Issues one command from IDLE, waits (bounded) for the response, samples it, then consumes it.
  task automatic run_op(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    r_lat = 0;
    while (bus.rsp_valid !== 1'b1 && r_lat < 100) begin
      @(negedge clk);
      r_lat++;
    end
    r_data  = bus.rsp_data;
    r_flags = {bus.flag_z, bus.flag_n, bus.flag_v};
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cmd_ready got %b want 0", bus.cmd_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rsp_data got %h want 0000", bus.rsp_data); end
    n_checks++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags got %b want 000", {bus.flag_z, bus.flag_n, bus.flag_v}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_ready got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_add();
    run_op(16'd0, 16'hFFFF, 16'h0001);
    n_checks++; if (r_lat != 1) begin n_fail++; $display("[TB] FAIL add_latency got %0d want 1", r_lat); end
    n_checks++; if (r_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL add_data got %h want 0000", r_data); end
    n_checks++; if (r_flags !== 3'b101) begin n_fail++; $display("[TB] FAIL add_flags_znv got %b want 101", r_flags); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL add_ready_after got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_sub();
    run_op(16'd1, 16'h0003, 16'h0005);
    n_checks++; if (r_data !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL sub_data got %h want fffe", r_data); end
    n_checks++; if (r_flags !== 3'b011) begin n_fail++; $display("[TB] FAIL sub_flags_znv got %b want 011", r_flags); end
    run_op(16'd8, 16'h1234, 16'h0001);
    n_checks++; if (r_flags[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL op8_flag_v got %b want 0", r_flags[0]); end
  endtask

  task automatic test_logic();
    run_op(16'd3, 16'h00F0, 16'h0F00);
    n_checks++; if (r_data !== 16'h0FF0) begin n_fail++; $display("[TB] FAIL or_data got %h want 0ff0", r_data); end
    n_checks++; if (r_flags !== 3'b000) begin n_fail++; $display("[TB] FAIL or_flags_znv got %b want 000", r_flags); end
    run_op(16'd4, 16'h1234, 16'h00FF);
    n_checks++; if (r_data !== 16'h12CB) begin n_fail++; $display("[TB] FAIL xor_data got %h want 12cb", r_data); end
    run_op(16'd5, 16'h0000, 16'h5555);
    n_checks++; if (r_data !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL not_data got %h want ffff", r_data); end
    n_checks++; if (r_flags !== 3'b010) begin n_fail++; $display("[TB] FAIL not_flags_znv got %b want 010", r_flags); end
  endtask

  task automatic test_mul();
    run_op(16'd6, 16'h0012, 16'h0034);
    n_checks++; if (r_lat != 16) begin n_fail++; $display("[TB] FAIL mul_latency got %0d want 16", r_lat); end
    n_checks++; if (r_data !== 16'h03A8) begin n_fail++; $display("[TB] FAIL mul_data got %h want 03a8", r_data); end
    n_checks++; if (r_flags !== 3'b000) begin n_fail++; $display("[TB] FAIL mul_flags_znv got %b want 000", r_flags); end
    run_op(16'd6, 16'h8000, 16'h0002);
    n_checks++; if (r_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL mul_wrap_data got %h want 0000", r_data); end
    n_checks++; if (r_flags !== 3'b100) begin n_fail++; $display("[TB] FAIL mul_wrap_flags_znv got %b want 100", r_flags); end
    run_op(16'd6, 16'hFFFF, 16'h0003);
    n_checks++; if (r_data !== 16'hFFFD) begin n_fail++; $display("[TB] FAIL mul_carry_data got %h want fffd", r_data); end
    n_checks++; if (r_flags !== 3'b011) begin n_fail++; $display("[TB] FAIL mul_carry_flags_znv got %b want 011", r_flags); end
  endtask

  task automatic test_cmp_and();
    run_op(16'd7, 16'h0005, 16'h0005);
    n_checks++; if (r_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL cmp_eq_data got %h want 0000", r_data); end
    n_checks++; if (r_flags !== 3'b100) begin n_fail++; $display("[TB] FAIL cmp_eq_flags_znv got %b want 100", r_flags); end
    run_op(16'd2, 16'hF0F0, 16'h0F0F);
    n_checks++; if (r_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL and_data got %h want 0000", r_data); end
    n_checks++; if (r_flags !== 3'b100) begin n_fail++; $display("[TB] FAIL and_flags_znv got %b want 100", r_flags); end
    run_op(16'd7, 16'h0003, 16'h0005);
    n_checks++; if (r_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL cmp_lt_data got %h want 0000", r_data); end
    n_checks++; if (r_flags !== 3'b011) begin n_fail++; $display("[TB] FAIL cmp_lt_flags_znv got %b want 011", r_flags); end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 16'd4;
    bus.cmd_a     = 16'h1234;
    bus.cmd_b     = 16'h00FF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 16'd0;
    bus.cmd_a     = 16'h0001;
    bus.cmd_b     = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_rsp_valid[%0d] got %b want 1", i, bus.rsp_valid); end
      n_checks++; if (bus.rsp_data !== 16'h12CB) begin n_fail++; $display("[TB] FAIL bp_rsp_data[%0d] got %h want 12cb", i, bus.rsp_data); end
      n_checks++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000) begin n_fail++; $display("[TB] FAIL bp_flags[%0d] got %b want 000", i, {bus.flag_z, bus.flag_n, bus.flag_v}); end
      n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_cmd_ready[%0d] got %b want 0", i, bus.cmd_ready); end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_after got %b want 1", bus.cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_no_extra[%0d] got %b want 0", i, bus.rsp_valid); end
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    run_op(16'd5, 16'h0000, 16'h0000);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 16'd6;
    bus.cmd_a     = 16'h0012;
    bus.cmd_b     = 16'h0034;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_cmd_ready got %b want 0", bus.cmd_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rsp_valid got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL midrst_rsp_data got %h want 0000", bus.rsp_data); end
    n_checks++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000) begin n_fail++; $display("[TB] FAIL midrst_flags got %b want 000", {bus.flag_z, bus.flag_n, bus.flag_v}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_release_ready got %b want 1", bus.cmd_ready); end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("[TB] FAIL midrst_no_response got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_cmp_and();
    test_backpressure();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
